// File: rtl/par2ser_stream_if.sv
// Producer-side handshake and serial-link outputs of par2ser_stream, grouped as one bundle.
interface par2ser_stream_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic [DATA_W-1:0] parallel_data_in;
    logic              grant;
    logic              serial_data_out;
    logic              out_data;
    logic              word_done;
    logic              busy;

    modport master (
        output req, parallel_data_in,
        input  grant, serial_data_out, out_data, word_done, busy
    );

    modport slave (
        input  req, parallel_data_in,
        output grant, serial_data_out, out_data, word_done, busy
    );
endinterface

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with a one-word holding buffer so frames can stream back-to-back.
// One bit per p_clk, selectable shift order, optional forced idle gap after every word.
module par2ser_stream #(
    parameter int DATA_W     = 32,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 0
) (
    input  logic              p_clk,
    input  logic              n_rst,
    par2ser_stream_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_reg_q, hold_reg_d;
    logic [DATA_W-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              reload;
    logic              grant_int;
    logic              last_bit;

    assign grant_int = !hold_valid_q;
    assign last_bit  = (bit_cnt_q == LAST_BIT);

    always_ff @(posedge p_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_reg_q   <= '0;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_reg_q   <= hold_reg_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_reg_d   = hold_reg_q;
        shift_reg_d  = shift_reg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        reload       = 1'b0;

        // Accept and reload are mutually exclusive: accept needs the buffer empty, reload needs it full.
        if (bus.req && grant_int) begin
            hold_reg_d   = bus.parallel_data_in;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    reload = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (MSB_FIRST) begin
                    shift_reg_d = {shift_reg_q[DATA_W-2:0], 1'b0};
                end else begin
                    shift_reg_d = {1'b0, shift_reg_q[DATA_W-1:1]};
                end
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (hold_valid_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    if (hold_valid_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reload) begin
            shift_reg_d  = hold_reg_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
            state_d      = ST_SHIFT;
        end
    end

    assign bus.grant           = grant_int;
    assign bus.out_data        = (state_q == ST_SHIFT);
    assign bus.serial_data_out = bus.out_data &
                                 (MSB_FIRST ? shift_reg_q[DATA_W-1] : shift_reg_q[0]);
    assign bus.word_done       = bus.out_data && last_bit;
    assign bus.busy            = (state_q != ST_IDLE) || hold_valid_q;
endmodule
